// File: rtl/ooo_tag_pkg.sv
// Shared types and sizes for the out-of-order tag allocator.
// NUM_TAGS is fixed at 4 so a granted tag can drive a 2-to-4 one-hot decoder directly.
package ooo_tag_pkg;

  localparam int unsigned NUM_TAGS = 4;
  localparam int unsigned TAG_W    = 2;  // $clog2(NUM_TAGS)
  localparam int unsigned CNT_W    = 3;  // $clog2(NUM_TAGS + 1)

  typedef logic [TAG_W-1:0]    tag_t;
  typedef logic [NUM_TAGS-1:0] tag_mask_t;
  typedef logic [CNT_W-1:0]    cnt_t;

endpackage

// File: rtl/tag_free_list_if.sv
// Handshake bundle between the tag free list and its consumers.
//   alloc_req / alloc_en / alloc_tag : grant path (alloc_en + alloc_tag feed the write decoder)
//   release_valid / release_tag      : tag return path from retire/flush logic
//   free_count / empty / full        : registered occupancy status
//   err_double_free                  : sticky misuse flag
// Modports: master = consumer side, slave = free list.
interface tag_free_list_if;
  import ooo_tag_pkg::*;

  logic alloc_req;
  logic alloc_en;
  tag_t alloc_tag;
  logic release_valid;
  tag_t release_tag;
  cnt_t free_count;
  logic empty;
  logic full;
  logic err_double_free;

  modport master (
    output alloc_req, release_valid, release_tag,
    input  alloc_en, alloc_tag, free_count, empty, full, err_double_free
  );

  modport slave (
    input  alloc_req, release_valid, release_tag,
    output alloc_en, alloc_tag, free_count, empty, full, err_double_free
  );

endinterface

// File: rtl/tag_pri_enc4.sv
// 4-bit find-first-set: idx_o is the lowest set bit of mask_i, valid_o is any bit set.
// idx_o is 0 when nothing is set.
//   mask_i  : candidate mask
//   idx_o   : index of the lowest set bit
//   valid_o : mask_i != 0
module tag_pri_enc4
  import ooo_tag_pkg::*;
(
  input  tag_mask_t mask_i,
  output tag_t      idx_o,
  output logic      valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = |mask_i;
    // Scan downward so the lowest set bit is the last write.
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (mask_i[i]) idx_o = tag_t'(i);
    end
  end

endmodule

// File: rtl/tag_free_list.sv
// Free-list allocator for NUM_TAGS physical tags.
// Grants one free tag per cycle combinationally from the registered free mask, accepts one
// returned tag per cycle, keeps a registered free count and a sticky double-free error.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset (all tags free, error cleared)
//   bus   : tag_free_list_if slave modport (grant, release, status)
// Build option TAG_FREE_LIST_ROUND_ROBIN_EN: search for a free tag starting at rr_ptr and
// wrapping, instead of strict lowest-index priority. Ports are identical in both builds.
module tag_free_list
  import ooo_tag_pkg::*;
(
  input logic             clk,
  input logic             reset,
  tag_free_list_if.slave  bus
);

  tag_mask_t free_mask_q, free_mask_d;
  cnt_t      free_count_q, free_count_d;
  logic      err_q, err_d;

  tag_mask_t enc_mask;
  tag_t      enc_idx;
  logic      enc_valid;
  tag_t      grant_tag;
  logic      rel_ok;
  logic      rel_dup;

  tag_pri_enc4 u_pri_enc (
    .mask_i  (enc_mask),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

`ifdef TAG_FREE_LIST_ROUND_ROBIN_EN
  tag_t                    rr_ptr_q, rr_ptr_d;
  logic [2*NUM_TAGS-1:0]   mask_dbl;

  // Rotate so bit 0 of the encoder input is tag rr_ptr, then add rr_ptr back (mod 4).
  always_comb begin
    mask_dbl  = {free_mask_q, free_mask_q} >> rr_ptr_q;
    enc_mask  = mask_dbl[NUM_TAGS-1:0];
    grant_tag = enc_idx + rr_ptr_q;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (bus.alloc_en) rr_ptr_d = bus.alloc_tag + tag_t'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`else
  always_comb begin
    enc_mask  = free_mask_q;
    grant_tag = enc_idx;
  end
`endif

  // Grant path: zero latency from the registered mask, no bypass of this cycle's release.
  always_comb begin
    bus.alloc_en  = bus.alloc_req & enc_valid;
    bus.alloc_tag = bus.alloc_en ? grant_tag : '0;
  end

  // A release of a tag whose bit is already set (including the tag granted this cycle,
  // which is granted from the old mask) is a double free and is otherwise ignored.
  always_comb begin
    rel_ok  = bus.release_valid & ~free_mask_q[bus.release_tag];
    rel_dup = bus.release_valid &  free_mask_q[bus.release_tag];
  end

  always_comb begin
    free_mask_d = free_mask_q;
    if (rel_ok)       free_mask_d[bus.release_tag] = 1'b1;
    if (bus.alloc_en) free_mask_d[bus.alloc_tag]   = 1'b0;

    free_count_d = free_count_q - cnt_t'(bus.alloc_en) + cnt_t'(rel_ok);
    err_d        = err_q | rel_dup;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      free_mask_q  <= '1;
      free_count_q <= cnt_t'(NUM_TAGS);
      err_q        <= 1'b0;
    end else begin
      free_mask_q  <= free_mask_d;
      free_count_q <= free_count_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    bus.free_count      = free_count_q;
    bus.empty           = (free_count_q == '0);
    bus.full            = (free_count_q == cnt_t'(NUM_TAGS));
    bus.err_double_free = err_q;
  end

endmodule

// File: tb/tb_tag_free_list.sv
// Self-checking bench for tag_free_list: a table of per-cycle vectors plus a hand-written
// grant-order sequence whose expectations depend on TAG_FREE_LIST_ROUND_ROBIN_EN.
// Each vector gives the inputs for one cycle and the outputs/state expected just before
// that cycle's rising edge.
module tb_tag_free_list;

  typedef struct {
    logic       rst;
    logic       req;
    logic       rv;
    logic [1:0] rtag;
    logic       en;
    logic [1:0] tag;
    logic [2:0] cnt;
    logic [3:0] mask;
    logic       err;
  } vec_t;

  logic clk;
  logic reset;

  tag_free_list_if bus ();

  tag_free_list dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors;
  int   checks;
  int   step;
  vec_t sb[$];
  vec_t vecs[29];
  vec_t seq[7];

  function automatic vec_t mk(logic rst, logic req, logic rv, logic [1:0] rtag, logic en,
                              logic [1:0] tag, logic [2:0] cnt, logic [3:0] mask, logic err);
    vec_t v;
    v.rst = rst; v.req = req; v.rv = rv; v.rtag = rtag;
    v.en = en; v.tag = tag; v.cnt = cnt; v.mask = mask; v.err = err;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s step %0d: got=%0h want=%0h", nm, step, got, want);
    end
  endtask

  // Drive one cycle of stimulus; expectation goes to the scoreboard and is compared once
  // the combinational outputs have settled, well before the next rising edge.
  task automatic apply(vec_t v);
    vec_t e;
    @(negedge clk);
    reset             = v.rst;
    bus.alloc_req     = v.req;
    bus.release_valid = v.rv;
    bus.release_tag   = v.rtag;
    sb.push_back(v);
    #1;
    e = sb.pop_front();
    chk("alloc_en",        32'(bus.alloc_en),        32'(e.en));
    chk("alloc_tag",       32'(bus.alloc_tag),       32'(e.tag));
    chk("free_count",      32'(bus.free_count),      32'(e.cnt));
    chk("empty",           32'(bus.empty),           32'(e.cnt == 3'd0));
    chk("full",            32'(bus.full),            32'(e.cnt == 3'd4));
    chk("err_double_free", 32'(bus.err_double_free), 32'(e.err));
    chk("free_mask",       32'(dut.free_mask_q),     32'(e.mask));
    step++;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    step   = 0;

    //               rst req rv rtag  en tag cnt mask     err
    // Allocate until empty.
    vecs[0]  = mk(0, 1, 0, 2'd0, 1, 2'd0, 3'd4, 4'b1111, 0);
    vecs[1]  = mk(0, 1, 0, 2'd0, 1, 2'd1, 3'd3, 4'b1110, 0);
    vecs[2]  = mk(0, 1, 0, 2'd0, 1, 2'd2, 3'd2, 4'b1100, 0);
    vecs[3]  = mk(0, 1, 0, 2'd0, 1, 2'd3, 3'd1, 4'b1000, 0);
    vecs[4]  = mk(0, 1, 0, 2'd0, 0, 2'd0, 3'd0, 4'b0000, 0);
    // Empty + release: no bypass, granted next cycle.
    vecs[5]  = mk(0, 1, 1, 2'd2, 0, 2'd0, 3'd0, 4'b0000, 0);
    vecs[6]  = mk(0, 1, 0, 2'd0, 1, 2'd2, 3'd1, 4'b0100, 0);
    // Alloc + release of a different tag in the same cycle.
    vecs[7]  = mk(1, 0, 0, 2'd0, 0, 2'd0, 3'd0, 4'b0000, 0);
    vecs[8]  = mk(0, 1, 0, 2'd0, 1, 2'd0, 3'd4, 4'b1111, 0);
    vecs[9]  = mk(0, 1, 0, 2'd0, 1, 2'd1, 3'd3, 4'b1110, 0);
    vecs[10] = mk(0, 1, 1, 2'd0, 1, 2'd2, 3'd2, 4'b1100, 0);
    vecs[11] = mk(0, 0, 0, 2'd0, 0, 2'd0, 3'd2, 4'b1001, 0);
    // Double free while full; sticky until reset.
    vecs[12] = mk(1, 0, 0, 2'd0, 0, 2'd0, 3'd2, 4'b1001, 0);
    vecs[13] = mk(0, 0, 1, 2'd1, 0, 2'd0, 3'd4, 4'b1111, 0);
    vecs[14] = mk(0, 0, 0, 2'd0, 0, 2'd0, 3'd4, 4'b1111, 1);
    vecs[15] = mk(0, 0, 1, 2'd3, 0, 2'd0, 3'd4, 4'b1111, 1);
    vecs[16] = mk(0, 0, 0, 2'd0, 0, 2'd0, 3'd4, 4'b1111, 1);
    vecs[17] = mk(1, 0, 0, 2'd0, 0, 2'd0, 3'd4, 4'b1111, 1);
    // Same-tag alloc + release: alloc wins, error flagged.
    vecs[18] = mk(0, 1, 1, 2'd0, 1, 2'd0, 3'd4, 4'b1111, 0);
    vecs[19] = mk(0, 0, 0, 2'd0, 0, 2'd0, 3'd3, 4'b1110, 1);
    // Reset after three allocations; alloc_en follows alloc_req during reset.
    vecs[20] = mk(1, 0, 0, 2'd0, 0, 2'd0, 3'd3, 4'b1110, 1);
    vecs[21] = mk(0, 1, 0, 2'd0, 1, 2'd0, 3'd4, 4'b1111, 0);
    vecs[22] = mk(0, 1, 0, 2'd0, 1, 2'd1, 3'd3, 4'b1110, 0);
    vecs[23] = mk(0, 1, 0, 2'd0, 1, 2'd2, 3'd2, 4'b1100, 0);
    vecs[24] = mk(1, 1, 0, 2'd0, 1, 2'd3, 3'd1, 4'b1000, 0);
    vecs[25] = mk(0, 0, 0, 2'd0, 0, 2'd0, 3'd4, 4'b1111, 0);
    // Plain allocate then plain release.
    vecs[26] = mk(0, 1, 0, 2'd0, 1, 2'd0, 3'd4, 4'b1111, 0);
    vecs[27] = mk(0, 0, 1, 2'd0, 0, 2'd0, 3'd3, 4'b1110, 0);
    vecs[28] = mk(0, 0, 0, 2'd0, 0, 2'd0, 3'd4, 4'b1111, 0);

    // Grant order after reset: alloc, release 0, then allocate until empty.
    seq[0] = mk(1, 0, 0, 2'd0, 0, 2'd0, 3'd4, 4'b1111, 0);
    seq[1] = mk(0, 1, 0, 2'd0, 1, 2'd0, 3'd4, 4'b1111, 0);
    seq[2] = mk(0, 0, 1, 2'd0, 0, 2'd0, 3'd3, 4'b1110, 0);
`ifdef TAG_FREE_LIST_ROUND_ROBIN_EN
    seq[3] = mk(0, 1, 0, 2'd0, 1, 2'd1, 3'd4, 4'b1111, 0);
    seq[4] = mk(0, 1, 0, 2'd0, 1, 2'd2, 3'd3, 4'b1101, 0);
    seq[5] = mk(0, 1, 0, 2'd0, 1, 2'd3, 3'd2, 4'b1001, 0);
    seq[6] = mk(0, 1, 0, 2'd0, 1, 2'd0, 3'd1, 4'b0001, 0);  // wrap 3 -> 0
`else
    seq[3] = mk(0, 1, 0, 2'd0, 1, 2'd0, 3'd4, 4'b1111, 0);
    seq[4] = mk(0, 1, 0, 2'd0, 1, 2'd1, 3'd3, 4'b1110, 0);
    seq[5] = mk(0, 1, 0, 2'd0, 1, 2'd2, 3'd2, 4'b1100, 0);
    seq[6] = mk(0, 1, 0, 2'd0, 1, 2'd3, 3'd1, 4'b1000, 0);
`endif

    reset             = 1'b1;
    bus.alloc_req     = 1'b0;
    bus.release_valid = 1'b0;
    bus.release_tag   = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 29; i++) apply(vecs[i]);
    for (int i = 0; i < 7; i++) apply(seq[i]);
    // Final state must be empty in both builds.
    apply(mk(0, 1, 0, 2'd0, 0, 2'd0, 3'd0, 4'b0000, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
